gem_irq_coalescer: RTL and testbench

- Parametrised per-queue interrupt status/enable block with interrupt moderation. Generalises the fixed two-queue rxdone/txdone interrupt wiring to NQUEUES queues.
- Each queue direction (RX, TX) counts completion events and raises its ISR bit when a count threshold is reached or a timeout expires.
- Sits between the SP core's completion signalling and the AXI-lite MMR block; drives gem_irq and per-queue done lines.

---
 rtl/gem_irq_coalescer_pkg.sv | 29 ++
 rtl/gem_irq_coalescer_channel.sv | 81 ++++++++
 rtl/gem_irq_coalescer.sv | 152 +++++++++++++++
 tb/tb_gem_irq_coalescer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gem_irq_coalescer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sp_unit_config (package)
// Purpose  : Shared constants and enums for the GEM interrupt coalescer.
// Revision : 1.0 - initial release
// ============================================================================
package sp_unit_config;

    localparam int GEM_RXDONE_BITN = 0;
    localparam int GEM_TXDONE_BITN = 1;

    typedef enum logic [2:0] {
        REG_ISR        = 3'd0,
        REG_IER        = 3'd1,
        REG_RX_THRESH  = 3'd2,
        REG_RX_TIMEOUT = 3'd3,
        REG_TX_THRESH  = 3'd4,
        REG_TX_TIMEOUT = 3'd5,
        REG_RX_PENDING = 3'd6,
        REG_TX_PENDING = 3'd7
    } gem_reg_e;

    typedef enum logic [0:0] {
        CH_IDLE  = 1'b0,
        CH_ACCUM = 1'b1
    } ch_state_e;

endpackage
`default_nettype wire

// File: rtl/gem_irq_coalescer_channel.sv
`default_nettype none
// ============================================================================
// Module   : gem_irq_coalesce_channel
// Purpose  : One direction of one queue: counts events, fires on threshold
//            or on timeout measured from the first pending event.
// Revision : 1.0 - initial release
// ============================================================================
module gem_irq_coalesce_channel
    import sp_unit_config::*;
#(
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned TMR_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 event_in,
    input  logic [CNT_WIDTH-1:0] thresh,
    input  logic [TMR_WIDTH-1:0] timeout,
    output logic                 fire,
    output logic [CNT_WIDTH-1:0] pending
);

    ch_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] pending_q, pending_d;
    logic [TMR_WIDTH-1:0] timer_q, timer_d;

    logic [CNT_WIDTH-1:0] pend_inc;
    logic [CNT_WIDTH-1:0] thresh_eff;
    logic                 tmo_hit;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= CH_IDLE;
            pending_q <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        timer_d    = timer_q;
        fire       = 1'b0;
        // A zero threshold is treated as one, i.e. every event fires.
        thresh_eff = (thresh == '0) ? CNT_WIDTH'(1) : thresh;
        pend_inc   = (event_in && (pending_q != '1)) ? pending_q + CNT_WIDTH'(1) : pending_q;
        tmo_hit    = (timeout != '0) && (timer_q == timeout - TMR_WIDTH'(1));

        case (state_q)
            CH_IDLE: begin
                if (event_in) begin
                    if (thresh_eff == CNT_WIDTH'(1)) begin
                        fire = 1'b1;
                    end else begin
                        pending_d = CNT_WIDTH'(1);
                        state_d   = CH_ACCUM;
                    end
                end
            end
            CH_ACCUM: begin
                timer_d   = timer_q + TMR_WIDTH'(1);
                pending_d = pend_inc;
                if ((pend_inc >= thresh_eff) || tmo_hit) begin
                    fire      = 1'b1;
                    pending_d = '0;
                    timer_d   = '0;
                    state_d   = CH_IDLE;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    assign pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/gem_irq_coalescer.sv
`default_nettype none
// ============================================================================
// Module   : gem_irq_coalescer
// Purpose  : Per-queue RX/TX interrupt status, enable and moderation
//            registers with a registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module gem_irq_coalescer
    import sp_unit_config::*;
#(
    parameter int unsigned NQUEUES   = 2,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned TMR_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NQUEUES-1:0]     rx_event,
    input  logic [NQUEUES-1:0]     tx_event,
    input  logic                   cfg_we,
    input  logic                   cfg_re,
    input  logic [3:0]             cfg_queue,
    input  logic [2:0]             cfg_addr,
    input  logic [31:0]            cfg_wdata,
    output logic [31:0]            cfg_rdata,
    output logic [2*NQUEUES-1:0]   isr,
    output logic [NQUEUES-1:0]     irq_q,
    output logic                   gem_irq
);

    logic [2*NQUEUES-1:0]               isr_q, isr_d;
    logic [NQUEUES-1:0][1:0]            ier_q, ier_d;
    logic [NQUEUES-1:0][CNT_WIDTH-1:0]  rx_thresh_q, rx_thresh_d;
    logic [NQUEUES-1:0][CNT_WIDTH-1:0]  tx_thresh_q, tx_thresh_d;
    logic [NQUEUES-1:0][TMR_WIDTH-1:0]  rx_timeout_q, rx_timeout_d;
    logic [NQUEUES-1:0][TMR_WIDTH-1:0]  tx_timeout_q, tx_timeout_d;
    logic [31:0]                        rdata_q, rdata_d;

    logic [2*NQUEUES-1:0]               fire;
    logic [2*NQUEUES-1:0]               clr;
    logic [NQUEUES-1:0][CNT_WIDTH-1:0]  rx_pending;
    logic [NQUEUES-1:0][CNT_WIDTH-1:0]  tx_pending;
    logic [31:0]                        rd_val;
    logic                               unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            isr_q        <= '0;
            ier_q        <= '0;
            rx_thresh_q  <= '0;
            tx_thresh_q  <= '0;
            rx_timeout_q <= '0;
            tx_timeout_q <= '0;
            rdata_q      <= '0;
        end else begin
            isr_q        <= isr_d;
            ier_q        <= ier_d;
            rx_thresh_q  <= rx_thresh_d;
            tx_thresh_q  <= tx_thresh_d;
            rx_timeout_q <= rx_timeout_d;
            tx_timeout_q <= tx_timeout_d;
            rdata_q      <= rdata_d;
        end
    end

    // Loop decode keeps out-of-range queue indices from touching any state.
    always_comb begin
        ier_d        = ier_q;
        rx_thresh_d  = rx_thresh_q;
        tx_thresh_d  = tx_thresh_q;
        rx_timeout_d = rx_timeout_q;
        tx_timeout_d = tx_timeout_q;
        rdata_d      = rdata_q;
        clr          = '0;
        rd_val       = '0;

        for (int q = 0; q < NQUEUES; q++) begin
            if (cfg_queue == 4'(q)) begin
                case (gem_reg_e'(cfg_addr))
                    REG_ISR: begin
                        rd_val = 32'(isr_q[2*q +: 2]);
                        if (cfg_we) clr[2*q +: 2] = cfg_wdata[1:0];
                    end
                    REG_IER: begin
                        rd_val = 32'(ier_q[q]);
                        if (cfg_we) ier_d[q] = cfg_wdata[1:0];
                    end
                    REG_RX_THRESH: begin
                        rd_val = 32'(rx_thresh_q[q]);
                        if (cfg_we) rx_thresh_d[q] = cfg_wdata[CNT_WIDTH-1:0];
                    end
                    REG_RX_TIMEOUT: begin
                        rd_val = 32'(rx_timeout_q[q]);
                        if (cfg_we) rx_timeout_d[q] = cfg_wdata[TMR_WIDTH-1:0];
                    end
                    REG_TX_THRESH: begin
                        rd_val = 32'(tx_thresh_q[q]);
                        if (cfg_we) tx_thresh_d[q] = cfg_wdata[CNT_WIDTH-1:0];
                    end
                    REG_TX_TIMEOUT: begin
                        rd_val = 32'(tx_timeout_q[q]);
                        if (cfg_we) tx_timeout_d[q] = cfg_wdata[TMR_WIDTH-1:0];
                    end
                    REG_RX_PENDING: rd_val = 32'(rx_pending[q]);
                    REG_TX_PENDING: rd_val = 32'(tx_pending[q]);
                    default: rd_val = '0;
                endcase
            end
        end

        // A fire in the same cycle as a W1C keeps the bit set.
        isr_d = (isr_q & ~clr) | fire;
        if (cfg_re) rdata_d = rd_val;
    end

    for (genvar q = 0; q < NQUEUES; q++) begin : g_queue
        gem_irq_coalesce_channel #(
            .CNT_WIDTH (CNT_WIDTH),
            .TMR_WIDTH (TMR_WIDTH)
        ) u_rx (
            .clock    (clock),
            .resetn   (resetn),
            .event_in (rx_event[q]),
            .thresh   (rx_thresh_q[q]),
            .timeout  (rx_timeout_q[q]),
            .fire     (fire[2*q + GEM_RXDONE_BITN]),
            .pending  (rx_pending[q])
        );

        gem_irq_coalesce_channel #(
            .CNT_WIDTH (CNT_WIDTH),
            .TMR_WIDTH (TMR_WIDTH)
        ) u_tx (
            .clock    (clock),
            .resetn   (resetn),
            .event_in (tx_event[q]),
            .thresh   (tx_thresh_q[q]),
            .timeout  (tx_timeout_q[q]),
            .fire     (fire[2*q + GEM_TXDONE_BITN]),
            .pending  (tx_pending[q])
        );

        assign irq_q[q] = |(isr_q[2*q +: 2] & ier_q[q]);
    end

    assign isr       = isr_q;
    assign gem_irq   = |irq_q;
    assign cfg_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_gem_irq_coalescer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gem_irq_coalescer
// Purpose  : Scoreboard bench for gem_irq_coalescer built with four queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gem_irq_coalescer;
    import sp_unit_config::*;

    localparam int NQ   = 4;
    localparam int K_ISR = 0;
    localparam int K_IRQ = 1;
    localparam int K_GEM = 2;
    localparam int K_RD  = 3;

    logic              clock = 1'b0;
    logic              resetn;
    logic [NQ-1:0]     rx_event, tx_event;
    logic              cfg_we, cfg_re;
    logic [3:0]        cfg_queue;
    logic [2:0]        cfg_addr;
    logic [31:0]       cfg_wdata;
    logic [31:0]       cfg_rdata;
    logic [2*NQ-1:0]   isr;
    logic [NQ-1:0]     irq_q;
    logic              gem_irq;

    gem_irq_coalescer #(.NQUEUES(NQ), .CNT_WIDTH(8), .TMR_WIDTH(16)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .rx_event  (rx_event),
        .tx_event  (tx_event),
        .cfg_we    (cfg_we),
        .cfg_re    (cfg_re),
        .cfg_queue (cfg_queue),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .isr       (isr),
        .irq_q     (irq_q),
        .gem_irq   (gem_irq)
    );

    always #5 clock = ~clock;

    typedef struct { int cyc; int kind; logic [31:0] exp; string name; } pin_exp_t;
    typedef struct { logic [31:0] exp; string name; } rd_exp_t;

    pin_exp_t pin_q[$];
    rd_exp_t  rd_q[$];
    int       cyc = 0;
    logic     re_d = 1'b0;
    int       errors = 0;
    int       checks = 0;
    int       t0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(posedge clock) begin
        cyc  <= cyc + 1;
        re_d <= cfg_re;
    end

    // Monitor: read data is consumed whenever a read was issued last edge;
    // pin expectations are consumed at the cycle they were stamped with.
    rd_exp_t  mon_rd;
    pin_exp_t mon_pin;
    logic [31:0] mon_act;
    always @(negedge clock) begin
        if (re_d) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", cfg_rdata, 32'hDEAD_BEEF);
            end else begin
                mon_rd = rd_q.pop_front();
                check(mon_rd.name, cfg_rdata, mon_rd.exp);
            end
        end
        while (pin_q.size() > 0 && pin_q[0].cyc <= cyc) begin
            mon_pin = pin_q.pop_front();
            case (mon_pin.kind)
                K_ISR:   mon_act = 32'(isr);
                K_IRQ:   mon_act = 32'(irq_q);
                K_GEM:   mon_act = 32'(gem_irq);
                default: mon_act = cfg_rdata;
            endcase
            if (mon_pin.cyc < cyc) check({mon_pin.name, "_missed"}, 32'(cyc), 32'(mon_pin.cyc));
            else                   check(mon_pin.name, mon_act, mon_pin.exp);
        end
    end

    function automatic void expect_at(int c, int k, logic [31:0] e, string nm);
        pin_q.push_back('{c, k, e, nm});
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input int q, input gem_reg_e a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_queue = 4'(q); cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic rd(input int q, input gem_reg_e a, input logic [31:0] e, input string nm);
        rd_q.push_back('{e, nm});
        cfg_re = 1'b1; cfg_queue = 4'(q); cfg_addr = a;
        step();
        cfg_re = 1'b0;
    endtask

    task automatic pulse_rx(input int q);
        rx_event[q] = 1'b1;
        step();
        rx_event = '0;
    endtask

    task automatic pulse_tx(input int q);
        tx_event[q] = 1'b1;
        step();
        tx_event = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; rx_event = '0; tx_event = '0;
        cfg_we = 1'b0; cfg_re = 1'b0; cfg_queue = '0; cfg_addr = '0; cfg_wdata = '0;
        step(3);
        expect_at(cyc, K_ISR, 0, "reset_isr");
        expect_at(cyc, K_IRQ, 0, "reset_irq");
        expect_at(cyc, K_GEM, 0, "reset_gem");
        expect_at(cyc, K_RD,  0, "reset_rdata");
        resetn = 1'b1;
        step(2);

        // Immediate fire and W1C clear
        wr(0, REG_RX_THRESH, 0);
        wr(0, REG_IER, 1);
        expect_at(cyc, K_ISR, 0, "t1_isr_before");
        pulse_rx(0);
        expect_at(cyc, K_ISR, 32'h01, "t1_isr_set");
        expect_at(cyc, K_IRQ, 32'h1,  "t1_irq");
        expect_at(cyc, K_GEM, 1,      "t1_gem");
        wr(0, REG_ISR, 1);
        expect_at(cyc, K_ISR, 0, "t1_isr_cleared");
        expect_at(cyc, K_GEM, 0, "t1_gem_cleared");
        rd(0, REG_ISR, 0, "t1_isr_reg");

        // Count threshold on q1 TX
        wr(1, REG_TX_THRESH, 4);
        wr(1, REG_TX_TIMEOUT, 0);
        repeat (3) begin
            pulse_tx(1);
            step();
        end
        expect_at(cyc, K_ISR, 0, "t2_isr_after3");
        rd(1, REG_TX_PENDING, 3, "t2_pending3");
        pulse_tx(1);
        expect_at(cyc, K_ISR, 32'h08, "t2_isr_after4");
        expect_at(cyc, K_GEM, 0,      "t2_gem_masked");
        rd(1, REG_TX_PENDING, 0, "t2_pending0");
        wr(1, REG_ISR, 2);

        // Timeout from the first pending event
        wr(0, REG_RX_THRESH, 10);
        wr(0, REG_RX_TIMEOUT, 20);
        rd(0, REG_RX_TIMEOUT, 20, "t3_timeout_rb");
        pulse_rx(0);
        t0 = cyc;
        for (int k = 0; k < 20; k++) expect_at(t0 + k, K_ISR, 0, "t3_no_early");
        expect_at(t0 + 20, K_ISR, 32'h01, "t3_timeout_fire");
        step(21);
        wr(0, REG_ISR, 1);

        // W1C and fire on the same bit in the same cycle
        wr(0, REG_RX_TIMEOUT, 0);
        wr(0, REG_RX_THRESH, 1);
        pulse_rx(0);
        expect_at(cyc, K_ISR, 32'h01, "t4_set");
        rd_q.push_back('{32'h1, "t4_read_preclear"});
        rx_event[0] = 1'b1; cfg_we = 1'b1; cfg_re = 1'b1;
        cfg_queue = 4'd0; cfg_addr = REG_ISR; cfg_wdata = 32'h1;
        step();
        rx_event = '0; cfg_we = 1'b0; cfg_re = 1'b0;
        expect_at(cyc, K_ISR, 32'h01, "t4_set_wins");
        wr(0, REG_ISR, 1);
        expect_at(cyc, K_ISR, 0, "t4_clear");

        // Lowering the threshold below the pending count
        wr(0, REG_RX_THRESH, 8);
        repeat (5) begin
            pulse_rx(0);
            step();
        end
        rd(0, REG_RX_PENDING, 5, "t5_pending5");
        wr(0, REG_RX_THRESH, 4);
        expect_at(cyc,     K_ISR, 0,      "t5_not_yet");
        expect_at(cyc + 1, K_ISR, 32'h01, "t5_fire");
        step();
        rd(0, REG_RX_PENDING, 0, "t5_pending0");
        wr(0, REG_ISR, 1);

        // Masking, enable, and out-of-range queue access
        pulse_rx(3);
        expect_at(cyc, K_ISR, 32'h40, "t6_isr_q3");
        expect_at(cyc, K_IRQ, 0,      "t6_irq_masked");
        expect_at(cyc, K_GEM, 0,      "t6_gem_masked");
        wr(3, REG_IER, 3);
        expect_at(cyc, K_IRQ, 32'h8, "t6_irq_q3");
        expect_at(cyc, K_GEM, 1,     "t6_gem");
        rd(3, REG_IER, 3, "t6_ier_rb");
        wr(5, REG_IER, 3);
        wr(5, REG_RX_THRESH, 32'h55);
        rd(5, REG_IER, 0, "t6_q5_ier");
        rd(5, REG_RX_THRESH, 0, "t6_q5_thresh");
        rd(1, REG_RX_THRESH, 0, "t6_no_alias_thresh");
        rd(1, REG_IER, 0, "t6_no_alias_ier");
        expect_at(cyc, K_IRQ, 32'h8, "t6_irq_unchanged");
        wr(2, REG_IER, 32'hFFFF_FFFF);
        rd(2, REG_IER, 3, "t6_ier_high_bits");
        expect_at(cyc + 1, K_RD, 3, "t6_rdata_hold");
        step(2);

        // Reset during accumulation discards pending events
        wr(0, REG_RX_THRESH, 8);
        pulse_rx(0);
        pulse_rx(0);
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        step();
        expect_at(cyc, K_ISR, 0, "t7_isr_after_reset");
        rd(0, REG_RX_PENDING, 0, "t7_pending_after_reset");
        step(3);

        check("queues_drained", 32'(rd_q.size() + pin_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
